// File: rtl/sender_buffer_ctrl.sv
// Circular word buffer feeding a four-phase Request/Ack transmitter.
// Burst mode sends a snapshot of the buffer on start; streaming mode drains continuously.
module sender_buffer_ctrl #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] data,
  input  logic              write,
  input  logic              start,
  input  logic              mode,
  input  logic              Ack,
  output logic              Request,
  output logic [DATA_W-1:0] sdrDataOut,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              overflow
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] REQ_HI = 3'd3;
  localparam logic [2:0] REQ_LO = 3'd4;

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [ADDR_W:0]   left;
  logic [2:0]        state;
  logic              mode_q;
  logic              push, pop;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  // full is the registered value: a pop in the same cycle does not make room
  assign push  = write && !full;
  assign pop   = (state == LOAD);

  // storage is never reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk)
    if (push) mem[wp] <= data;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      left       <= '0;
      mode_q     <= 1'b0;
      Request    <= 1'b0;
      overflow   <= 1'b0;
      sdrDataOut <= '0;
    end else begin
      overflow <= write && full;
      if (push) wp <= wp + PTR_ONE;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          Request <= 1'b0;
          if (!mode && start && !empty) begin
            left   <= count;
            mode_q <= 1'b0;
            state  <= LOAD;
          end else if (mode && !empty) begin
            mode_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          sdrDataOut <= mem[rp];
          rp         <= rp + PTR_ONE;
          if (!mode_q) left <= left - CNT_ONE;
          state      <= SETUP;
        end
        SETUP: begin
          Request <= 1'b1;
          state   <= REQ_HI;
        end
        REQ_HI: begin
          if (Ack) begin
            Request <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          // the next word only starts once the receiver has released Ack
          if (!Ack) begin
            if (mode_q) state <= empty ? IDLE : LOAD;
            else        state <= (left != '0) ? LOAD : IDLE;
          end
        end
        default: begin
          Request <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sender_buffer_ctrl.sv
// Directed/random bench for sender_buffer_ctrl with a queue-based reference of the word stream.
module tb_sender_buffer_ctrl;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          Reset, write, start, mode, Ack;
  logic [DW-1:0] data;
  logic          Request, full, empty, busy, overflow;
  logic [DW-1:0] sdrDataOut;
  logic [AW:0]   count;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            rx_cnt   = 0;
  logic [DW-1:0] mq [$];

  sender_buffer_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .Reset(Reset), .data(data), .write(write), .start(start),
    .mode(mode), .Ack(Ack), .Request(Request), .sdrDataOut(sdrDataOut),
    .count(count), .full(full), .empty(empty), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one-cycle write; the model accepts the word unless it already holds DEPTH
  task automatic push(input logic [DW-1:0] w);
    logic exp_ovf;
    exp_ovf = (mq.size() >= DP);
    if (!exp_ovf) mq.push_back(w);
    data  = w;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  // receiver: dly<0 picks a random ack delay per word, hold keeps Ack high after Request falls
  task automatic receive(input int n, input int dly, input int hold);
    int t, d;
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!Request && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!Request) begin
        chk("req_timeout", 32'(Request), 1);
        return;
      end
      if (mq.size() == 0) begin
        chk("unexpected_word", 32'(mq.size()), 1);
        return;
      end
      w = mq.pop_front();
      rx_cnt++;
      chk("rx_data", 32'(sdrDataOut), 32'(w));
      d = (dly < 0) ? int'($urandom_range(3, 0)) : dly;
      repeat (d) begin
        @(negedge clk);
        chk("req_hold", 32'(Request), 1);
        chk("data_stable", 32'(sdrDataOut), 32'(w));
      end
      Ack = 1'b1;
      @(negedge clk);
      chk("req_fall", 32'(Request), 0);
      repeat (hold) begin
        @(negedge clk);
        chk("req_stuck", 32'(Request), 0);
      end
      Ack = 1'b0;
    end
  endtask

  initial begin
    int t;
    logic idle_seen;
    logic [DW-1:0] w;
    Reset = 1'b1; write = 1'b0; start = 1'b0; mode = 1'b0; Ack = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;

    // reset values and start on an empty buffer
    chk("rst_request", 32'(Request), 0);
    chk("rst_data", 32'(sdrDataOut), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    pulse_start();
    t = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) t++;
    end
    chk("empty_start_busy_cycles", 32'(t), 0);

    // burst of three with start-to-data latency
    push(16'h1111); push(16'h2222); push(16'h3333);
    chk("burst_count3", 32'(count), 3);
    pulse_start();
    chk("burst_busy", 32'(busy), 1);
    @(negedge clk);
    chk("burst_lat_data", 32'(sdrDataOut), 32'h1111);
    chk("burst_lat_req0", 32'(Request), 0);
    @(negedge clk);
    chk("burst_lat_req1", 32'(Request), 1);
    receive(3, 2, 0);
    wait_idle("burst_idle");
    chk("burst_count0", 32'(count), 0);
    chk("burst_data_held", 32'(sdrDataOut), 32'h3333);

    // push during the LOAD cycle, then a stuck Ack
    push(16'h0aaa); push(16'h0bbb);
    pulse_start();
    w = DW'($urandom);
    mq.push_back(w);
    data = w; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    chk("pushpop_count", 32'(count), 2);
    receive(2, 0, 6);
    wait_idle("pushpop_idle");
    chk("pushpop_left", 32'(count), 32'(mq.size()));
    pulse_start();
    receive(1, -1, 0);
    wait_idle("pushpop_idle2");
    chk("pushpop_drained", 32'(count), 0);

    // fill, overflow, snapshot burst with pushes mid-burst across the wrap
    for (int i = 0; i < DP; i++) push(DW'($urandom));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), DP);
    push(16'hDEAD);
    @(negedge clk);
    chk("ovf_pulse_end", 32'(overflow), 0);
    chk("ovf_count", 32'(count), DP);
    rx_cnt = 0;
    pulse_start();
    fork
      receive(DP, -1, 0);
      begin
        for (int i = 0; i < 5; i++) begin
          t = 0;
          while (rx_cnt <= i && t < 200) begin
            @(negedge clk);
            t++;
          end
          push(DW'($urandom));
        end
      end
    join
    wait_idle("snap_idle");
    chk("snap_sent", 32'(rx_cnt), DP);
    chk("snap_count", 32'(count), 5);
    chk("snap_model", 32'(mq.size()), 5);
    pulse_start();
    receive(5, -1, 0);
    wait_idle("snap2_idle");
    chk("snap2_count", 32'(count), 0);

    // streaming latency and back-to-back continuation
    mode = 1'b1;
    push(16'hA5A5);
    chk("stream_req_e0", 32'(Request), 0);
    chk("stream_count", 32'(count), 1);
    @(negedge clk);
    chk("stream_req_e1", 32'(Request), 0);
    chk("stream_busy_e1", 32'(busy), 1);
    @(negedge clk);
    chk("stream_data_e2", 32'(sdrDataOut), 32'hA5A5);
    chk("stream_req_e2", 32'(Request), 0);
    @(negedge clk);
    chk("stream_req_e3", 32'(Request), 1);
    rx_cnt = 0;
    idle_seen = 1'b0;
    fork
      receive(2, 2, 0);
      begin
        @(negedge clk);
        push(DW'($urandom));
        t = 0;
        while (rx_cnt < 2 && t < 300) begin
          @(negedge clk);
          if (!busy) idle_seen = 1'b1;
          t++;
        end
      end
    join
    chk("stream_b2b", 32'(idle_seen), 0);
    wait_idle("stream_idle");
    chk("stream_count0", 32'(count), 0);
    mode = 1'b0;

    // reset in REQ_HI with Ack left high afterwards
    push(16'h1234);
    pulse_start();
    t = 0;
    while (!Request && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_req_seen", 32'(Request), 1);
    Reset = 1'b1; Ack = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    mq.delete();
    chk("mid_rst_request", 32'(Request), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(sdrDataOut), 0);
    w = DW'($urandom);
    push(w);
    pulse_start();
    Ack = 1'b0;
    receive(1, 1, 0);
    wait_idle("mid_idle");
    chk("mid_count0", 32'(count), 0);
    chk("mid_data", 32'(sdrDataOut), 32'(w));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
